// File: rtl/axi_lite_mbox_hub.sv
// axi_lite_mbox_hub: NUM_CH independent 32-bit FIFO mailboxes of DEPTH entries
// behind a single AXI-Lite slave port, one interrupt line per channel.
// Optional feature: define MBOX_HUB_ERRCNT_EN to add per-channel 16-bit
// saturating overflow/underflow counters at offset 0x18.
module axi_lite_mbox_hub #(
    parameter int NUM_CH     = 4,
    parameter int DEPTH      = 8,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [ADDR_WIDTH-1:0] aw_addr_i,
    input  logic                  aw_valid_i,
    output logic                  aw_ready_o,
    input  logic [31:0]           w_data_i,
    input  logic [3:0]            w_strb_i,
    input  logic                  w_valid_i,
    output logic                  w_ready_o,
    output logic [1:0]            b_resp_o,
    output logic                  b_valid_o,
    input  logic                  b_ready_i,
    input  logic [ADDR_WIDTH-1:0] ar_addr_i,
    input  logic                  ar_valid_i,
    output logic                  ar_ready_o,
    output logic [31:0]           r_data_o,
    output logic [1:0]            r_resp_o,
    output logic                  r_valid_o,
    input  logic                  r_ready_i,
    output logic [NUM_CH-1:0]     irq_o
);
    localparam int              PW          = $clog2(DEPTH);
    localparam int              LW          = PW + 1;
    localparam logic [LW-1:0]   DEPTH_L     = LW'(DEPTH);
    localparam logic [4:0]      NUM_CH_L    = 5'(NUM_CH);
    localparam logic [1:0]      RESP_OKAY   = 2'b00;
    localparam logic [1:0]      RESP_SLVERR = 2'b10;
    localparam logic [1:0]      RESP_DECERR = 2'b11;
    // Word offsets (addr[7:2]) of the per-channel registers.
    localparam logic [5:0]      OFF_DATA    = 6'h00;
    localparam logic [5:0]      OFF_STATUS  = 6'h01;
    localparam logic [5:0]      OFF_THRESH  = 6'h02;
    localparam logic [5:0]      OFF_IRQ_EN  = 6'h03;
    localparam logic [5:0]      OFF_PEND    = 6'h04;
    localparam logic [5:0]      OFF_CTRL    = 6'h05;
    localparam logic [5:0]      OFF_ERRCNT  = 6'h06;

    typedef enum logic [1:0] {ST_IDLE, ST_WRESP, ST_RRESP} state_e;
    state_e state_q, state_d;

    logic [31:0]       mem_q    [NUM_CH][DEPTH];
    logic [PW-1:0]     wptr_q   [NUM_CH], wptr_d   [NUM_CH];
    logic [PW-1:0]     rptr_q   [NUM_CH], rptr_d   [NUM_CH];
    logic [LW-1:0]     level_q  [NUM_CH], level_d  [NUM_CH];
    logic [7:0]        thresh_q [NUM_CH], thresh_d [NUM_CH];
    logic [1:0]        irq_en_q [NUM_CH], irq_en_d [NUM_CH];
    logic [1:0]        pend_q   [NUM_CH], pend_d   [NUM_CH];
    logic [1:0]        clr      [NUM_CH];
    logic [NUM_CH-1:0] irq_q, push, pop, flush, data_err, thr_hit;
    logic [1:0]        b_resp_q, r_resp_q, wr_resp, rd_resp;
    logic [31:0]       r_data_q, rd_data;
    logic              wr_go, rd_go, wr_ok, rd_ok;
    logic [3:0]        wr_ch, rd_ch;
    logic [5:0]        wr_off, rd_off;
    logic              unused_bits;

    // Handshakes: a write needs AW and W together and wins over a read.
    assign wr_go      = (state_q == ST_IDLE) && aw_valid_i && w_valid_i && !rst_i;
    assign rd_go      = (state_q == ST_IDLE) && ar_valid_i && !(aw_valid_i && w_valid_i) && !rst_i;
    assign aw_ready_o = wr_go;
    assign w_ready_o  = wr_go;
    assign ar_ready_o = rd_go;

    assign wr_ch  = aw_addr_i[11:8];
    assign wr_off = aw_addr_i[7:2];
    assign rd_ch  = ar_addr_i[11:8];
    assign rd_off = ar_addr_i[7:2];
    assign wr_ok  = ({1'b0, wr_ch} < NUM_CH_L);
    assign rd_ok  = ({1'b0, rd_ch} < NUM_CH_L);

    assign unused_bits = ^{w_strb_i, aw_addr_i[ADDR_WIDTH-1:12], aw_addr_i[1:0],
                           ar_addr_i[ADDR_WIDTH-1:12], ar_addr_i[1:0]};

    assign b_resp_o = b_resp_q;
    assign r_resp_o = r_resp_q;
    assign r_data_o = r_data_q;
    assign irq_o    = irq_q;

`ifdef MBOX_HUB_ERRCNT_EN
    logic [15:0] errcnt_q [NUM_CH], errcnt_d [NUM_CH];

    // Error counters: any write clears, DATA errors increment up to saturation
    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            errcnt_d[c] = errcnt_q[c];
            if (wr_go && wr_ok && wr_ch == 4'(c) && wr_off == OFF_ERRCNT)
                errcnt_d[c] = '0;
            else if (data_err[c] && errcnt_q[c] != 16'hFFFF)
                errcnt_d[c] = errcnt_q[c] + 16'd1;
        end
    end

    // Error counter registers
    always_ff @(posedge clk_i) begin
        for (int c = 0; c < NUM_CH; c++)
            errcnt_q[c] <= rst_i ? 16'h0000 : errcnt_d[c];
    end
`endif

    // FSM next state and response-valid outputs
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no latch is inferred.
        state_d   = state_q;
        b_valid_o = 1'b0;
        r_valid_o = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (wr_go)      state_d = ST_WRESP;
                else if (rd_go) state_d = ST_RRESP;
            end
            ST_WRESP: begin
                b_valid_o = 1'b1;
                if (b_ready_i) state_d = ST_IDLE;
            end
            ST_RRESP: begin
                r_valid_o = 1'b1;
                if (r_ready_i) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Register decode, responses and per-channel next state
    always_comb begin
        wr_resp  = RESP_DECERR;
        rd_resp  = RESP_DECERR;
        rd_data  = '0;
        push     = '0;
        pop      = '0;
        flush    = '0;
        data_err = '0;
        thr_hit  = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            clr[c]      = 2'b00;
            wptr_d[c]   = wptr_q[c];
            rptr_d[c]   = rptr_q[c];
            level_d[c]  = level_q[c];
            thresh_d[c] = thresh_q[c];
            irq_en_d[c] = irq_en_q[c];

            if (wr_ok && wr_ch == 4'(c)) begin
                wr_resp = RESP_OKAY;
                case (wr_off)
                    OFF_DATA: begin
                        if (level_q[c] == DEPTH_L) begin
                            wr_resp     = RESP_SLVERR;
                            data_err[c] = wr_go;
                        end else begin
                            push[c] = wr_go;
                        end
                    end
                    OFF_STATUS, OFF_ERRCNT: ;
                    OFF_THRESH: if (wr_go) thresh_d[c] = w_data_i[7:0];
                    OFF_IRQ_EN: if (wr_go) irq_en_d[c] = w_data_i[1:0];
                    OFF_PEND:   if (wr_go) clr[c] = w_data_i[1:0];
                    OFF_CTRL:   flush[c] = wr_go && w_data_i[0];
                    default:    wr_resp = RESP_DECERR;
                endcase
            end

            if (rd_ok && rd_ch == 4'(c)) begin
                rd_resp = RESP_OKAY;
                case (rd_off)
                    OFF_DATA: begin
                        if (level_q[c] == '0) begin
                            rd_resp     = RESP_SLVERR;
                            data_err[c] = rd_go;
                        end else begin
                            rd_data = mem_q[c][rptr_q[c]];
                            pop[c]  = rd_go;
                        end
                    end
                    OFF_STATUS: rd_data = {8'h00, 8'(level_q[c]), 14'h0000,
                                           level_q[c] == DEPTH_L, level_q[c] == '0};
                    OFF_THRESH: rd_data = {24'h0, thresh_q[c]};
                    OFF_IRQ_EN: rd_data = {30'h0, irq_en_q[c]};
                    OFF_PEND:   rd_data = {30'h0, pend_q[c]};
                    OFF_CTRL:   ;
                    OFF_ERRCNT: begin
`ifdef MBOX_HUB_ERRCNT_EN
                        rd_data = {16'h0, errcnt_q[c]};
`endif
                    end
                    default:    rd_resp = RESP_DECERR;
                endcase
            end

            if (flush[c]) begin
                wptr_d[c]  = '0;
                rptr_d[c]  = '0;
                level_d[c] = '0;
            end else if (push[c]) begin
                wptr_d[c]  = wptr_q[c] + PW'(1);
                level_d[c] = level_q[c] + LW'(1);
            end else if (pop[c]) begin
                rptr_d[c]  = rptr_q[c] + PW'(1);
                level_d[c] = level_q[c] - LW'(1);
            end

            // Set conditions use the post-update level so a reaching push flags at its own edge.
            thr_hit[c] = (thresh_d[c] != 8'h00) && (8'(level_d[c]) >= thresh_d[c]);
            pend_d[c]  = (pend_q[c] & ~clr[c]) | {data_err[c], thr_hit[c]};
        end
    end

    // FSM state register
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses nonblocking assignments so all flops see pre-edge values.
        if (rst_i) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Channel control registers, responses and registered interrupts
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int c = 0; c < NUM_CH; c++) begin
                wptr_q[c]   <= '0;
                rptr_q[c]   <= '0;
                level_q[c]  <= '0;
                thresh_q[c] <= '0;
                irq_en_q[c] <= '0;
                pend_q[c]   <= '0;
            end
            irq_q    <= '0;
            b_resp_q <= RESP_OKAY;
            r_resp_q <= RESP_OKAY;
            r_data_q <= '0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                wptr_q[c]   <= wptr_d[c];
                rptr_q[c]   <= rptr_d[c];
                level_q[c]  <= level_d[c];
                thresh_q[c] <= thresh_d[c];
                irq_en_q[c] <= irq_en_d[c];
                pend_q[c]   <= pend_d[c];
                irq_q[c]    <= |(pend_q[c] & irq_en_q[c]);
            end
            if (wr_go) b_resp_q <= wr_resp;
            if (rd_go) begin
                r_data_q <= rd_data;
                r_resp_q <= rd_resp;
            end
        end
    end

    // FIFO storage array
    always_ff @(posedge clk_i) begin
        // NOTE: storage has no reset; level and pointers alone decide which entries are valid.
        for (int c = 0; c < NUM_CH; c++)
            if (push[c]) mem_q[c][wptr_q[c]] <= w_data_i;
    end

endmodule

// File: doc/axi_lite_mbox_hub.md
# axi_lite_mbox_hub

Parametrised multi-channel AXI-Lite mailbox hub, the successor to the fixed two-channel host/cluster mailbox pair. It provides `NUM_CH` independent 32-bit FIFO mailboxes of depth `DEPTH` behind one AXI-Lite slave port. Each channel has a programmable fill-level interrupt threshold, a sticky error flag, a flush control and its own interrupt line. It sits as a master-port target of the host/cluster AXI-Lite crossbar; the crossbar strips the base address.

## Interface
- Reset: one clock; reset is synchronous and active-high.
- Parameters:
  - `NUM_CH`, default 4: channel count, range 1..16.
  - `DEPTH`, default 8: FIFO entries per channel; power of two, at least 2.
  - `ADDR_WIDTH`, default 32: AXI-Lite address width. Only `addr[11:0]` is decoded.
- Clock and reset:
  - `clk_i` in, 1: clock.
  - `rst_i` in, 1: synchronous active-high reset.
- Write address:
  - `aw_addr_i` in, ADDR_WIDTH: write address.
  - `aw_valid_i` in, 1; `aw_ready_o` out, 1.
- Write data:
  - `w_data_i` in, 32: write data.
  - `w_strb_i` in, 4: ignored. Every write is treated as full-word.
  - `w_valid_i` in, 1; `w_ready_o` out, 1.
- Write response:
  - `b_resp_o` out, 2: write response.
  - `b_valid_o` out, 1; `b_ready_i` in, 1.
- Read address:
  - `ar_addr_i` in, ADDR_WIDTH: read address.
  - `ar_valid_i` in, 1; `ar_ready_o` out, 1.
- Read data:
  - `r_data_i`… `r_data_o` out, 32: read data.
  - `r_resp_o` out, 2: read response.
  - `r_valid_o` out, 1; `r_ready_i` in, 1.
- Interrupts:
  - `irq_o` out, NUM_CH: per-channel interrupt, active high, level.

## Operation
- Address decode:
  - Channel index `ch = addr[11:8]`; register offset `off = addr[7:0]`; `addr[1:0]` ignored.
  - `ch >= NUM_CH` or an unmapped offset returns DECERR (2'b11) with no side effect. Reads return data 0.
- Per-channel registers:
  - 0x00 DATA: write pushes `w_data_i`; read pops the head.
    - Push when full: data dropped, SLVERR (2'b10), ERR pending set.
    - Pop when empty: data 0, SLVERR, ERR pending set.
  - 0x04 STATUS (RO): bit0 empty, bit1 full, [23:16] level (0..DEPTH). Writes OKAY, no effect.
  - 0x08 THRESH (RW, 8 bits): THRESH pending condition is `level >= THRESH` and `THRESH != 0`.
  - 0x0C IRQ_EN (RW): bit0 THRESH, bit1 ERR.
  - 0x10 IRQ_PEND: bit0 THRESH, bit1 ERR; write-1-to-clear.
    - If the set condition holds in the same cycle as a clear, set wins.
    - THRESH re-sets every cycle while its condition holds.
  - 0x14 CTRL: writing bit0 = 1 flushes the FIFO (level becomes 0). Reads 0.
  - 0x18 ERRCNT: see Configuration.
- Interrupt: `irq_o[c] = |(IRQ_PEND[c] & IRQ_EN[c])`, registered.
- FIFO: circular buffer with read/write pointers of width log2(DEPTH), plus a level counter. Pointers wrap modulo DEPTH.
- FSM states: IDLE, WRESP, RRESP.
  - IDLE:
    - If `aw_valid_i && w_valid_i`: accept both, execute the write, go to WRESP.
    - Else if `ar_valid_i`: accept, execute the read, go to RRESP.
    - Write wins over read when both arrive in the same cycle.
  - WRESP: `b_valid_o = 1`. Returns to IDLE on `b_ready_i`.
  - RRESP: `r_valid_o = 1`; `r_data_o`/`r_resp_o` held stable. Returns to IDLE on `r_ready_i`.
- A lone AW without W, or W without AW, is not accepted; it waits.

## Timing
- `aw_ready_o = w_ready_o = (state==IDLE) & aw_valid_i & w_valid_i & ~rst_i`.
- `ar_ready_o = (state==IDLE) & ar_valid_i & ~(aw_valid_i & w_valid_i) & ~rst_i`.
- Register, FIFO and pointer updates occur at the clock edge of the address handshake.
- `b_valid_o`/`r_valid_o` assert in the next cycle; minimum 1-cycle latency. One outstanding transaction in total.
- Back-to-back throughput: one transaction every 2 cycles when the response is consumed immediately.
- `irq_o` reflects a pending/enable change 1 cycle after the causing edge.
  - Example: a push at edge N reaching THRESH sets PEND at N and `irq_o` at N+1.
- Reset values: `b_valid_o`, `r_valid_o`, `b_resp_o`, `r_resp_o`, `r_data_o`, `irq_o` = 0.
  - Ready outputs are 0 while `rst_i` is high.
  - All FIFOs empty; THRESH, IRQ_EN, IRQ_PEND, ERRCNT = 0.
- Reset mid-transaction: the pending response is dropped without being issued; state goes to IDLE next cycle.

## Configuration
- `MBOX_HUB_ERRCNT_EN` defined:
  - Per-channel 16-bit saturating counter at 0x18, incremented on every overflow/underflow SLVERR. It saturates at 0xFFFF.
  - Any write to 0x18 clears it, OKAY.
- Not defined:
  - 0x18 reads 0 with OKAY.
  - Writes to 0x18 are ignored with OKAY.
  - No counter flops are synthesised.

## Test plan
- Reset: hold `rst_i` 3 cycles → all outputs 0, STATUS of ch0 reads 0x0000_0001.
- Ch2 fill/drain: push 0xA0..0xA7 (DEPTH 8) → STATUS 0x0008_0002; 8 pops return 0xA0..0xA7 in order, all OKAY.
- Overflow/underflow: 9th push to a full ch1 → SLVERR, data lost, PEND bit1 = 1. Pop on empty ch3 → SLVERR, data 0. With the macro, ERRCNT = 1.
- Threshold IRQ: ch0 THRESH = 3, IRQ_EN = 1; push 3 words → `irq_o[0]` rises 1 cycle after the 3rd handshake. W1C while level is 3 → stays 1. Pop 1 and W1C → 0.
- Same-cycle AW/W and AR: write wins; AR accepted after B completes. `b_ready_i` held low 5 cycles → `b_valid_o` and `b_resp_o` stable.
- Decode: access to `ch = NUM_CH` or offset 0x40 → DECERR, no state change. CTRL flush on ch0 with level 5 → STATUS level 0 next read.
